// File: rtl/stall_unit_if.sv
// ID-stage hazard inputs and stall outputs of the stall unit, bundled as one port.
// The FSM state is exported on fsm_state so checkers can follow the stall sequence.
interface stall_unit_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode_id;
  logic [4:0]           rs1_id;
  logic [4:0]           rs2_id;
  logic                 rs1_used_id;
  logic                 rs2_used_id;
  logic [4:0]           rd_ex;
  logic                 reg_write_ex;
  logic                 mem_read_ex;
  logic [4:0]           rd_mem;
  logic                 mem_read_mem;
  logic                 flush_id;
  logic                 stall;
  logic                 pc_en;
  logic                 if_id_en;
  logic                 id_ex_bubble;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [1:0]           fsm_state;

  // Pipeline side: presents ID/EX/MEM info, consumes stall controls.
  modport master (
    output opcode_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem, flush_id,
    input  stall, pc_en, if_id_en, id_ex_bubble, stall_cnt, fsm_state
  );

  modport slave (
    input  opcode_id, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           rd_ex, reg_write_ex, mem_read_ex, rd_mem, mem_read_mem, flush_id,
    output stall, pc_en, if_id_en, id_ex_bubble, stall_cnt, fsm_state
  );
endinterface

// File: rtl/stall_unit.sv
// Load-use / branch-operand hazard detection for a 5-stage pipeline with ID-resolved
// branches. Stall is combinational from the inputs; the FSM shapes 2-cycle branch stalls.
module stall_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  stall_unit_if.slave  bus
);
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_COOL = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 stall_raw;
  logic                 stall;
  logic                 m_ex, m_mem;
  logic                 is_br, is_exempt;
  logic                 h2, h1;

  // x0 is hard-wired zero, so a write to it can never create a dependency.
  assign m_ex  = bus.reg_write_ex && (bus.rd_ex != 5'd0) &&
                 ((bus.rs1_used_id && (bus.rs1_id == bus.rd_ex)) ||
                  (bus.rs2_used_id && (bus.rs2_id == bus.rd_ex)));
  assign m_mem = bus.mem_read_mem && (bus.rd_mem != 5'd0) &&
                 ((bus.rs1_used_id && (bus.rs1_id == bus.rd_mem)) ||
                  (bus.rs2_used_id && (bus.rs2_id == bus.rd_mem)));

  assign is_br     = (bus.opcode_id == OP_BR);
  assign is_exempt = (bus.opcode_id == OP_JAL) || (bus.opcode_id == OP_JALR) ||
                     (bus.opcode_id == OP_LUI) || (bus.opcode_id == OP_AUIPC);

  // H2 is tested first so it wins over a simultaneous MEM-stage load match.
  assign h2 = is_br && m_ex && bus.mem_read_ex;
  assign h1 = (is_br && m_ex && !bus.mem_read_ex) ||
              (is_br && m_mem) ||
              (!is_br && !is_exempt && m_ex && bus.mem_read_ex);

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.flush_id) begin
          if (h2) begin
            stall_raw = 1'b1;
            state_d   = ST_HOLD;
          end else if (h1) begin
            stall_raw = 1'b1;
            state_d   = ST_COOL;
          end
        end
      end
      ST_HOLD: begin
        if (bus.flush_id) begin
          state_d = ST_IDLE;
        end else begin
          stall_raw = 1'b1;
          state_d   = ST_COOL;
        end
      end
      ST_COOL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset overrides the stall immediately, even mid-HOLD.
  assign stall = stall_raw && !reset;

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.pc_en        = !stall;
  assign bus.if_id_en     = !stall;
  assign bus.id_ex_bubble = stall;
  assign bus.stall_cnt    = cnt_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_stall_unit.sv
// Directed scoreboard bench for stall_unit: a 32-bit-counter and a 3-bit-counter
// instance share identical stimulus so counter saturation is observed alongside.
module tb_stall_unit;
  localparam int W = 41;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_COOL = 2'd2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  stall_unit_if #(.CNT_WIDTH(32)) bus_w ();
  stall_unit_if #(.CNT_WIDTH(3))  bus_n ();

  stall_unit #(.CNT_WIDTH(32)) dut_w (.clk(clk), .reset(rst), .bus(bus_w));
  stall_unit #(.CNT_WIDTH(3))  dut_n (.clk(clk), .reset(rst), .bus(bus_n));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2,
                       input logic [4:0] rdex, input logic rwex, input logic mrex,
                       input logic [4:0] rdmem, input logic mrmem,
                       input logic flush, input logic r);
    bus_w.opcode_id = op;    bus_n.opcode_id = op;
    bus_w.rs1_id = rs1;      bus_n.rs1_id = rs1;
    bus_w.rs2_id = rs2;      bus_n.rs2_id = rs2;
    bus_w.rs1_used_id = u1;  bus_n.rs1_used_id = u1;
    bus_w.rs2_used_id = u2;  bus_n.rs2_used_id = u2;
    bus_w.rd_ex = rdex;      bus_n.rd_ex = rdex;
    bus_w.reg_write_ex = rwex; bus_n.reg_write_ex = rwex;
    bus_w.mem_read_ex = mrex;  bus_n.mem_read_ex = mrex;
    bus_w.rd_mem = rdmem;      bus_n.rd_mem = rdmem;
    bus_w.mem_read_mem = mrmem; bus_n.mem_read_mem = mrmem;
    bus_w.flush_id = flush;  bus_n.flush_id = flush;
    rst = r;
  endtask

  task automatic nop();
    drive(OP_ALU, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string tag, input logic e_stall, input logic [1:0] e_state,
                     input int e_cnt);
    logic [2:0] e_small;
    e_small = (e_cnt > 7) ? 3'd7 : 3'(e_cnt);
    exp_q.push_back({e_stall, !e_stall, !e_stall, e_stall, e_state, 32'(e_cnt), e_small});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      string        tag;
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      act_v = {bus_w.stall, bus_w.pc_en, bus_w.if_id_en, bus_w.id_ex_bubble,
               bus_w.fsm_state, bus_w.stall_cnt, bus_n.stall_cnt};
      checks++;
      if (act_v !== exp_v || bus_n.stall !== exp_v[W-1]) begin
        errors++;
        $display("FAIL %s: got stall/pc/ifid/bub=%b state=%0d cnt=%0d cnt3=%0d (nstall=%b), expected %b state=%0d cnt=%0d cnt3=%0d",
                 tag, act_v[40:37], act_v[36:35], act_v[34:3], act_v[2:0], bus_n.stall,
                 exp_v[40:37], exp_v[36:35], exp_v[34:3], exp_v[2:0]);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    nop();
    @(posedge clk);
    #1;

    // Reset holds stall low even with a live load-use hazard.
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    cyc("reset_hazard", 1'b0, S_IDLE, 0);
    nop(); cyc("post_reset", 1'b0, S_IDLE, 0);

    // Load x5 in EX, ADD x6,x5,x7 in ID: one stall.
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lu_stall", 1'b1, S_IDLE, 0);
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("lu_cool", 1'b0, S_COOL, 1);
    nop(); cyc("lu_idle", 1'b0, S_IDLE, 1);

    // Load x5 in EX, BEQ x5,x0: two stalls through HOLD.
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("h2_first", 1'b1, S_IDLE, 1);
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("h2_hold", 1'b1, S_HOLD, 2);
    cyc("h2_cool", 1'b0, S_COOL, 3);
    nop(); cyc("h2_idle", 1'b0, S_IDLE, 3);

    // ALU x3 in EX, BNE x3,x4: one stall; rd_ex=0 with rs1=x0: none.
    drive(OP_BR, 5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("h1b_stall", 1'b1, S_IDLE, 3);
    cyc("h1b_cool", 1'b0, S_COOL, 4);
    nop(); cyc("h1b_idle", 1'b0, S_IDLE, 4);
    drive(OP_BR, 5'd0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("x0_no_stall", 1'b0, S_IDLE, 4);

    // Load x5 in MEM, BEQ x7,x5: one stall; ALU in MEM: none.
    drive(OP_BR, 5'd7, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    cyc("h1m_stall", 1'b1, S_IDLE, 4);
    cyc("h1m_cool", 1'b0, S_COOL, 5);
    drive(OP_BR, 5'd7, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    cyc("mem_alu_none", 1'b0, S_IDLE, 5);

    // Exempt opcodes never stall, even with a matching rs1.
    drive(OP_JAL, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("jal_exempt", 1'b0, S_IDLE, 5);
    drive(OP_JALR, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("jalr_exempt", 1'b0, S_IDLE, 5);
    drive(OP_LUI, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("lui_exempt", 1'b0, S_IDLE, 5);
    drive(OP_AUIPC, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("auipc_exempt", 1'b0, S_IDLE, 5);
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("alu_fwd_none", 1'b0, S_IDLE, 5);

    // Flush in HOLD ends the stall and returns to IDLE.
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("flh_first", 1'b1, S_IDLE, 5);
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    cyc("flh_hold", 1'b0, S_HOLD, 6);
    nop(); cyc("flh_idle", 1'b0, S_IDLE, 6);

    // Flush in IDLE suppresses; flush in COOL is irrelevant.
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("fl_idle", 1'b0, S_IDLE, 6);
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("flc_stall", 1'b1, S_IDLE, 6);
    drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    cyc("flc_cool", 1'b0, S_COOL, 7);
    nop(); cyc("flc_idle", 1'b0, S_IDLE, 7);

    // H2 and H1m together: H2 wins (two stalls).
    drive(OP_BR, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    cyc("both_first", 1'b1, S_IDLE, 7);
    cyc("both_hold", 1'b1, S_HOLD, 8);
    cyc("both_cool", 1'b0, S_COOL, 9);
    nop(); cyc("both_idle", 1'b0, S_IDLE, 9);

    // Reset during HOLD aborts the stall and clears the counter.
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc("rh_first", 1'b1, S_IDLE, 9);
    drive(OP_BR, 5'd5, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    cyc("rh_hold_reset", 1'b0, S_HOLD, 10);
    nop(); cyc("rh_after", 1'b0, S_IDLE, 0);

    // Ten load-use stalls: the 3-bit counter saturates at 7.
    for (int i = 0; i < 10; i++) begin
      drive(OP_ALU, 5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("sat_stall", 1'b1, S_IDLE, i);
      cyc("sat_cool", 1'b0, S_COOL, i + 1);
    end
    nop(); cyc("sat_final", 1'b0, S_IDLE, 10);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
